// File: rtl/spm_pkg.sv
// Shared definitions for the RISC_SPM core, its memory and the boot loader.
package spm_pkg;

  localparam int unsigned SPM_ADDR_W = 8;
  localparam int unsigned SPM_DATA_W = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } boot_state_t;

endpackage

// File: rtl/spm_boot_csum.sv
// Modulo-2**DATA_W running sum of program beats, compared against the
// checksum carried by the final beat. Used only when BOOT_CHECKSUM_EN is defined.
module spm_boot_csum #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] expected,
  output logic              match
);

  logic [DATA_W-1:0] acc;

  // Accumulator: zeroed on entry to LOAD, sums every non-final accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + data;
    end
  end

  assign match = (acc == expected);

endmodule

// File: rtl/spm_boot_loader.sv
// Program loader for the RISC_SPM memory: clears every word, streams an
// (address, data) program into the RAM write port, then releases the CPU.
// Optional feature macro: BOOT_CHECKSUM_EN (final beat carries a checksum).
module spm_boot_loader
  import spm_pkg::*;
#(
  parameter int unsigned ADDR_W = SPM_ADDR_W,
  parameter int unsigned DATA_W = SPM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  boot_state_t       state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_d, rdy_d, cpu_rst_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              accept;

  assign accept = in_valid && in_ready;

`ifdef BOOT_CHECKSUM_EN
  logic csum_match;
  logic err_d;

  spm_boot_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      ((state_q == CLEAR) && cnt_q[ADDR_W]),
    .add      (accept && !in_last),
    .data     (in_data),
    .expected (in_data),
    .match    (csum_match)
  );
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    rdy_d     = 1'b0;
    cpu_rst_d = 1'b0;
    done_d    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      CLEAR: begin
        // Counter is one bit wider than the address so reaching the depth
        // is visible in its MSB rather than wrapping back to 0.
        if (!cnt_q[ADDR_W]) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = '0;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          rdy_d   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        rdy_d = 1'b1;
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = in_addr;
          wdata_d = in_data;
          if (in_last) begin
            rdy_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            // Final beat is the checksum, not program data.
            we_d    = 1'b0;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            state_d = csum_match ? RUN : ERR;
`else
            state_d = RUN;
`endif
          end
        end
      end
      RUN: begin
        // Restart issues clear address 0 on the same edge, so the counter
        // resumes from 1 to keep CLEAR at exactly 2**ADDR_W writes.
        if (boot_req) begin
          state_d = CLEAR;
          we_d    = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = {{ADDR_W{1'b0}}, 1'b1};
        end else begin
          cpu_rst_d = 1'b1;
          done_d    = 1'b1;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ERR: begin
        if (boot_req) begin
          state_d = CLEAR;
          we_d    = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = {{ADDR_W{1'b0}}, 1'b1};
        end else begin
          err_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State, clear counter and all outputs registered; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      in_ready  <= 1'b0;
      cpu_rst   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      in_ready  <= rdy_d;
      cpu_rst   <= cpu_rst_d;
      done      <= done_d;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Checksum failure flag, held while in ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
